// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin requester bank and its arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Contents: idx_w() index-width helper, default port index type, output
// register state encoding.
package rr_pkg;

  // Width of a port index; a single-port system still needs one bit.
  function automatic int idx_w(input int n);
    if (n < 2) return 1;
    return $clog2(n);
  endfunction

  localparam int NUM_PORTS_DEF = 4;
  localparam int IDX_W_DEF     = idx_w(NUM_PORTS_DEF);

  typedef logic [IDX_W_DEF-1:0] port_idx_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_HOLD  = 1'b1
  } out_state_t;

endpackage

// File: rtl/rr_req_bank_if.sv
// Bundle of client push ports, arbiter req/gnt and shared output handshake.
// Latency: n/a (wires only).
// Backpressure: full_o per client port, out_ready_i on the shared output.
// Ports: push_i/push_data_i/full_o (clients), req_o/gnt_i (arbiter),
// out_valid_o/out_ready_i/out_data_o/out_port_o (downstream), err_o.
interface rr_req_bank_if
  import rr_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8,
  parameter int IDX_W     = idx_w(NUM_PORTS)
);

  logic [NUM_PORTS-1:0]        push_i;
  logic [NUM_PORTS*DATA_W-1:0] push_data_i;
  logic [NUM_PORTS-1:0]        full_o;
  logic [NUM_PORTS-1:0]        req_o;
  logic [NUM_PORTS-1:0]        gnt_i;
  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [DATA_W-1:0]           out_data_o;
  logic [IDX_W-1:0]            out_port_o;
  logic                        err_o;

  // Design side.
  modport slave (
    input  push_i, push_data_i, gnt_i, out_ready_i,
    output full_o, req_o, out_valid_o, out_data_o, out_port_o, err_o
  );

  // Environment side: clients, arbiter and downstream sink.
  modport master (
    output push_i, push_data_i, gnt_i, out_ready_i,
    input  full_o, req_o, out_valid_o, out_data_o, out_port_o, err_o
  );

endinterface

// File: rtl/rr_req_fifo.sv
// Per-port queue of DEPTH words with wrap-bit pointers.
// Latency: push visible as !empty_o after one edge; head is combinational.
// Backpressure: push ignored while full_o; pop ignored while empty_o.
// Ports: push_i/push_data_i enqueue, pop_i dequeue, pop_data_o head word,
// empty_o/full_o status from registered pointers.
module rr_req_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] push_data_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int AW = $clog2(DEPTH);

  // One extra MSB distinguishes full from empty when the address bits match.
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data_i;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: empty pointers hide stale contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rr_req_bank.sv
// Per-port request queues feeding one shared valid/ready output via an arbiter.
// Latency: push->req_o 1 cycle; gnt_i->out_valid_o 1 cycle; 1 word/cycle.
// Backpressure: req_o gated to zero while the output holds an unaccepted word.
// Ports: clk, reset_n (async active-low), bus (rr_req_bank_if.slave) carrying
// client pushes, arbiter req/gnt, shared output and sticky err_o.
module rr_req_bank
  import rr_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  rr_req_bank_if.slave bus
);

  localparam int IDX_W = idx_w(NUM_PORTS);

  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] fifo_full;
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] pop;
  logic [DATA_W-1:0]    head_dat [NUM_PORTS];

  out_state_t        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  port_q, port_d;
  logic              err_q, err_d;

  logic              slot_free;
  logic              gnt_any;
  logic              gnt_onehot;
  logic              gnt_legal;
  logic              gnt_illegal;
  logic [IDX_W-1:0]  gnt_idx;
  logic [DATA_W-1:0] gnt_dat;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    rr_req_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .push_i      (bus.push_i[i]),
      .pop_i       (pop[i]),
      .push_data_i (bus.push_data_i[i*DATA_W +: DATA_W]),
      .pop_data_o  (head_dat[i]),
      .empty_o     (fifo_empty[i]),
      .full_o      (fifo_full[i])
    );
  end

  // Requests come from registered state and out_ready_i only, so the
  // arbiter's combinational grant path cannot loop back into req.
  assign slot_free = (state_q == OUT_EMPTY) || bus.out_ready_i;
  assign req       = ~fifo_empty & {NUM_PORTS{slot_free}};

  // x & (x-1) clears the lowest set bit; zero result means at most one bit.
  assign gnt_any     = |bus.gnt_i;
  assign gnt_onehot  = gnt_any &&
                       ((bus.gnt_i & (bus.gnt_i - NUM_PORTS'(1))) == '0);
  assign gnt_legal   = gnt_onehot && ((bus.gnt_i & ~req) == '0);
  assign gnt_illegal = gnt_any && !gnt_legal;
  assign pop         = bus.gnt_i & {NUM_PORTS{gnt_legal}};

  // Index/data select; only meaningful when the grant is one-hot.
  always_comb begin
    gnt_idx = '0;
    gnt_dat = head_dat[0];
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (bus.gnt_i[i]) begin
        gnt_idx = IDX_W'(i);
        gnt_dat = head_dat[i];
      end
    end
  end

  // Output register. A legal grant implies slot_free, so a load in HOLD
  // always coincides with the current word being accepted.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    port_d  = port_q;
    err_d   = err_q | gnt_illegal;
    case (state_q)
      OUT_EMPTY: begin
        if (gnt_legal) begin
          state_d = OUT_HOLD;
          data_d  = gnt_dat;
          port_d  = gnt_idx;
        end
      end
      OUT_HOLD: begin
        if (gnt_legal) begin
          data_d = gnt_dat;
          port_d = gnt_idx;
        end else if (bus.out_ready_i) begin
          state_d = OUT_EMPTY;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= OUT_EMPTY;
      data_q  <= '0;
      port_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      port_q  <= port_d;
      err_q   <= err_d;
    end
  end

  assign bus.full_o      = fifo_full;
  assign bus.req_o       = req;
  assign bus.out_valid_o = (state_q == OUT_HOLD);
  assign bus.out_data_o  = data_q;
  assign bus.out_port_o  = port_q;
  assign bus.err_o       = err_q;

endmodule

// File: doc/rr_req_bank.md
# rr_req_bank

Requester-side companion to the round-robin arbiter. It holds per-port transaction queues and raises `req_o` toward the arbiter for every port with pending work. It accepts the arbiter's one-hot `gnt_i` in the same cycle and forwards the granted port's head word onto a single shared valid/ready output. It sits between the N client ports and the shared resource, with the arbiter in the loop.

## Interface
Parameters:
- `NUM_PORTS`, 4, number of client ports (≥2).
- `DATA_W`, 8, payload width.
- `DEPTH`, 4, per-port queue depth (power of 2, ≥2).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `push_i`  in  NUM_PORTS  per-port enqueue strobe.
- `push_data_i`  in  NUM_PORTS*DATA_W  per-port payload; port i occupies bits [i*DATA_W +: DATA_W].
- `full_o`  out  NUM_PORTS  per-port queue full.
- `req_o`  out  NUM_PORTS  request vector to arbiter.
- `gnt_i`  in  NUM_PORTS  one-hot grant from arbiter, combinational from `req_o`.
- `out_valid_o`  out  1  shared output holds a word.
- `out_ready_i`  in  1  downstream accepts the word.
- `out_data_o`  out  DATA_W  forwarded payload.
- `out_port_o`  out  $clog2(NUM_PORTS)  source port index of `out_data_o`.
- `err_o`  out  1  sticky protocol-error flag.

## Operation
- Per-port FIFO: push when `push_i[i] && !full_o[i]`; a push to a full queue is dropped with no state change.
- `slot_free = !out_valid_o || out_ready_i`.
- `req_o[i] = !empty[i] && slot_free`, decoded from registered FIFO state only.
- Legal grant: `gnt_i` is one-hot and `(gnt_i & req_o) == gnt_i`.
  - Pops that port's head.
  - Loads `out_data_o`/`out_port_o` on the next edge.
  - Sets `out_valid_o`.
- Output register states:
  - EMPTY: `out_valid_o`=0.
  - HOLD: `out_valid_o`=1, word held stable while `!out_ready_i`.
  - EMPTY→HOLD on a legal grant.
  - HOLD→EMPTY on `out_ready_i` with no legal grant.
  - HOLD→HOLD (reload) on `out_ready_i` plus a legal grant in the same cycle.
- Illegal grant (multi-hot, or any grant bit with its `req_o` bit low): no pop, no load, `err_o` set.
  - `gnt_i`=0 is never an error.
- `err_o` is cleared only by reset.
- Simultaneous push and pop on the same port: both occur, count unchanged, FIFO order preserved.

## Timing
- Reset values: `out_valid_o`=0, `out_data_o`=0, `out_port_o`=0, `req_o`=0, `full_o`=0, `err_o`=0. All queues are emptied.
- Reset asserted mid-operation: queued and held words are discarded immediately. No request is raised until a new push.
- Push to a request: a push at edge k makes `req_o[i]`=1 in cycle k+1.
- Grant to output: a grant in cycle k gives `out_valid_o`=1 after edge k (visible in cycle k+1).
- Throughput is one word per cycle with `out_ready_i` held high.
- While HOLD and `!out_ready_i`, `req_o` is all-zero. No grant can be consumed.
- Pointer wrap: read and write pointers carry $clog2(DEPTH)+1 bits.
  - full = MSBs differ and lower bits equal.
  - empty = pointers equal.
  - Wrap past DEPTH is seamless.

## Structure
- Package `rr_pkg`: localparam function for the index width ($clog2(NUM_PORTS), minimum 1) and a typedef for the port index. The arbiter shares both.
- Sub-module `rr_req_fifo`, instantiated once per port.
  - Parameters: DEPTH, DATA_W.
  - Ports: push, pop, data in/out, empty, full.
- The top level holds request gating, grant legality check, one-hot-to-index encode and the output register.

## Test plan
- Reset with `reset_n`=0, then release → all outputs 0. After pushing 0xA1 on port 2: `req_o`=4'b0100 next cycle. Driving `gnt_i`=4'b0100 gives `out_data_o`=0xA1 and `out_port_o`=2 one cycle later.
- Push 0x11,0x22,0x33,0x44 into port 0; 5th push → `full_o[0]`=1, 5th word dropped. Grants drain 0x11..0x44 in order, then `req_o[0]`=0.
- Hold `out_ready_i`=0 while HOLD → `req_o`=0 and `out_data_o` stable for 5 cycles. Raise `out_ready_i` with a grant → back-to-back reload, no bubble.
- Drive `gnt_i`=4'b0011, or grant port 3 while its queue is empty → no pop, outputs unchanged, `err_o`=1 and stays 1.
- Same-cycle push and grant on port 1 at count 2 → count stays 2, output is the old head.
- Assert `reset_n` while HOLD with 3 words queued → `out_valid_o`=0 and `req_o`=0 immediately. Nothing is emitted after release.
